// File: rtl/multi_blob_tracker.sv
// Per-colour blob centroid tracker: accumulates pixel sums per channel during a frame, then
// divides with one shared bit-serial divider and applies exponential smoothing at frame end.
module multi_blob_tracker #(
  parameter int unsigned NCOLORS      = 4,
  parameter int unsigned CBITS        = 2,
  parameter int unsigned XBITS        = 10,
  parameter int unsigned YBITS        = 9,
  parameter int unsigned ACC_BITS     = 32,
  parameter int unsigned SMOOTH_SHIFT = 1,
  parameter int unsigned MIN_COUNT    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CBITS-1:0]           color,
  input  logic [XBITS-1:0]           pix_x,
  input  logic [YBITS-1:0]           pix_y,
  input  logic                       pix_valid,
  input  logic                       frame_flag,
  output logic                       busy,
  output logic                       dropped,
  output logic                       out_valid,
  output logic [NCOLORS-1:0]         ch_found,
  output logic [NCOLORS*XBITS-1:0]   ch_x,
  output logic [NCOLORS*YBITS-1:0]   ch_y
);
  localparam int unsigned CH_W = (NCOLORS > 1) ? $clog2(NCOLORS) : 1;
  localparam int unsigned BC_W = (ACC_BITS > 1) ? $clog2(ACC_BITS) : 1;

  typedef enum logic [2:0] {ACCUM, LOAD, DIVX, DIVY, UPDATE, DONE} state_t;

  state_t                state;
  logic                  frame_q;
  logic [ACC_BITS-1:0]   sum_x [NCOLORS];
  logic [ACC_BITS-1:0]   sum_y [NCOLORS];
  logic [ACC_BITS-1:0]   cnt   [NCOLORS];
  logic [NCOLORS-1:0]    ovf, lock, found_r;
  logic [XBITS-1:0]      pos_x [NCOLORS];
  logic [YBITS-1:0]      pos_y [NCOLORS];
  logic [CH_W-1:0]       ch;
  logic [BC_W-1:0]       bit_cnt;
  logic [ACC_BITS-1:0]   dividend, divisor, rem, quot;
  logic [XBITS-1:0]      avg_x;

  logic                  in_range_c, ge_c, found_c;
  logic [CBITS-1:0]      col_c;
  logic [ACC_BITS:0]     add_x_c, add_y_c, add_n_c, rem_sh_c;
  logic [ACC_BITS-1:0]   rem_nx_c, quot_nx_c;
  logic [YBITS-1:0]      avg_y_c;
  logic signed [XBITS:0] dx_c, smx_c;
  logic signed [YBITS:0] dy_c, smy_c;
  logic [CH_W-1:0]       ch_nx_c;
  logic [XBITS-1:0]      pos_x_n [NCOLORS];
  logic [YBITS-1:0]      pos_y_n [NCOLORS];
  logic [NCOLORS-1:0]    lock_n, found_n;

  // Saturating add; the MSB of the result flags saturation.
  function automatic logic [ACC_BITS:0] sat_add(input logic [ACC_BITS-1:0] a,
                                                input logic [ACC_BITS-1:0] b);
    logic [ACC_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_BITS] ? {1'b1, {ACC_BITS{1'b1}}} : s;
  endfunction

  always_comb begin
    in_range_c = (32'(color) < NCOLORS);
    col_c      = in_range_c ? color : '0;
    add_x_c    = sat_add(sum_x[col_c], ACC_BITS'(pix_x));
    add_y_c    = sat_add(sum_y[col_c], ACC_BITS'(pix_y));
    add_n_c    = sat_add(cnt[col_c], ACC_BITS'(1));
    // One restoring-division step.
    rem_sh_c   = {rem, dividend[ACC_BITS-1]};
    ge_c       = (rem_sh_c >= {1'b0, divisor});
    rem_nx_c   = ge_c ? ACC_BITS'(rem_sh_c - {1'b0, divisor}) : ACC_BITS'(rem_sh_c);
    quot_nx_c  = {quot[ACC_BITS-2:0], ge_c};
    avg_y_c    = YBITS'(quot);
    ch_nx_c    = ch + CH_W'(1);
    found_c    = (cnt[ch] >= ACC_BITS'(MIN_COUNT)) && !ovf[ch];
    dx_c       = $signed({1'b0, avg_x}) - $signed({1'b0, pos_x[ch]});
    smx_c      = $signed({1'b0, pos_x[ch]}) + (dx_c >>> SMOOTH_SHIFT);
    dy_c       = $signed({1'b0, avg_y_c}) - $signed({1'b0, pos_y[ch]});
    smy_c      = $signed({1'b0, pos_y[ch]}) + (dy_c >>> SMOOTH_SHIFT);
    pos_x_n    = pos_x;
    pos_y_n    = pos_y;
    lock_n     = lock;
    found_n    = found_r;
    if (state == UPDATE) begin
      found_n[ch] = found_c;
      lock_n[ch]  = found_c;
      if (found_c) begin
        pos_x_n[ch] = lock[ch] ? XBITS'(smx_c) : avg_x;
        pos_y_n[ch] = lock[ch] ? YBITS'(smy_c) : avg_y_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACCUM;
      frame_q   <= 1'b0;
      busy      <= 1'b0;
      dropped   <= 1'b0;
      out_valid <= 1'b0;
      ch_found  <= '0;
      ch_x      <= '0;
      ch_y      <= '0;
      ovf       <= '0;
      lock      <= '0;
      found_r   <= '0;
      ch        <= '0;
      bit_cnt   <= '0;
      dividend  <= '0;
      divisor   <= '0;
      rem       <= '0;
      quot      <= '0;
      avg_x     <= '0;
      for (int k = 0; k < NCOLORS; k++) begin
        sum_x[k] <= '0;
        sum_y[k] <= '0;
        cnt[k]   <= '0;
        pos_x[k] <= '0;
        pos_y[k] <= '0;
      end
    end else begin
      frame_q   <= frame_flag;
      out_valid <= 1'b0;
      if (pix_valid && state != ACCUM) dropped <= 1'b1;
      case (state)
        ACCUM: begin
          if (pix_valid && in_range_c) begin
            sum_x[col_c] <= add_x_c[ACC_BITS-1:0];
            sum_y[col_c] <= add_y_c[ACC_BITS-1:0];
            cnt[col_c]   <= add_n_c[ACC_BITS-1:0];
            ovf[col_c]   <= ovf[col_c] | add_x_c[ACC_BITS] | add_y_c[ACC_BITS] | add_n_c[ACC_BITS];
          end
          if (frame_flag && !frame_q) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          ch       <= '0;
          dividend <= sum_x[0];
          divisor  <= cnt[0];
          rem      <= '0;
          quot     <= '0;
          bit_cnt  <= '0;
          state    <= DIVX;
        end
        DIVX, DIVY: begin
          rem      <= rem_nx_c;
          quot     <= quot_nx_c;
          dividend <= {dividend[ACC_BITS-2:0], 1'b0};
          bit_cnt  <= bit_cnt + BC_W'(1);
          if (bit_cnt == BC_W'(ACC_BITS - 1)) begin
            bit_cnt <= '0;
            if (state == DIVX) begin
              avg_x    <= XBITS'(quot_nx_c);
              dividend <= sum_y[ch];
              rem      <= '0;
              quot     <= '0;
              state    <= DIVY;
            end else begin
              state <= UPDATE;
            end
          end
        end
        UPDATE: begin
          pos_x   <= pos_x_n;
          pos_y   <= pos_y_n;
          lock    <= lock_n;
          found_r <= found_n;
          if (ch == CH_W'(NCOLORS - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            ch_found  <= found_n;
            for (int k = 0; k < NCOLORS; k++) begin
              ch_x[k*XBITS +: XBITS] <= pos_x_n[k];
              ch_y[k*YBITS +: YBITS] <= pos_y_n[k];
            end
          end else begin
            ch       <= ch_nx_c;
            dividend <= sum_x[ch_nx_c];
            divisor  <= cnt[ch_nx_c];
            rem      <= '0;
            quot     <= '0;
            state    <= DIVX;
          end
        end
        DONE: begin
          if (!frame_flag) begin
            for (int k = 0; k < NCOLORS; k++) begin
              sum_x[k] <= '0;
              sum_y[k] <= '0;
              cnt[k]   <= '0;
            end
            ovf     <= '0;
            dropped <= 1'b0;
            busy    <= 1'b0;
            state   <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_blob_tracker.sv
// Bench for multi_blob_tracker: three instances (defaults, NCOLORS=3, ACC_BITS=12) share stimulus
// and are checked against a per-instance arithmetic model plus hand-derived frame vectors.
module tb_multi_blob_tracker;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  color;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_valid;
  logic        frame_flag;

  logic        busy_w [3];
  logic        drop_w [3];
  logic        ovw    [3];
  logic [3:0]  f0, f2;
  logic [2:0]  f1;
  logic [39:0] x0, x2;
  logic [29:0] x1;
  logic [35:0] y0, y2;
  logic [26:0] y1;
  logic [3:0]  fnd_a [3];
  logic [39:0] x_a   [3];
  logic [35:0] y_a   [3];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multi_blob_tracker u0 (.clk(clk), .reset(reset), .color(color), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .frame_flag(frame_flag), .busy(busy_w[0]), .dropped(drop_w[0]),
    .out_valid(ovw[0]), .ch_found(f0), .ch_x(x0), .ch_y(y0));
  multi_blob_tracker #(.NCOLORS(3)) u1 (.clk(clk), .reset(reset), .color(color), .pix_x(pix_x),
    .pix_y(pix_y), .pix_valid(pix_valid), .frame_flag(frame_flag), .busy(busy_w[1]),
    .dropped(drop_w[1]), .out_valid(ovw[1]), .ch_found(f1), .ch_x(x1), .ch_y(y1));
  multi_blob_tracker #(.ACC_BITS(12)) u2 (.clk(clk), .reset(reset), .color(color), .pix_x(pix_x),
    .pix_y(pix_y), .pix_valid(pix_valid), .frame_flag(frame_flag), .busy(busy_w[2]),
    .dropped(drop_w[2]), .out_valid(ovw[2]), .ch_found(f2), .ch_x(x2), .ch_y(y2));

  assign fnd_a[0] = f0;
  assign fnd_a[1] = {1'b0, f1};
  assign fnd_a[2] = f2;
  assign x_a[0]   = x0;
  assign x_a[1]   = {10'd0, x1};
  assign x_a[2]   = x2;
  assign y_a[0]   = y0;
  assign y_a[1]   = {9'd0, y1};
  assign y_a[2]   = y2;

  // Reference model: per instance, per channel sums, smoothing state and reported outputs.
  int     NC [3] = '{4, 3, 4};
  int     AB [3] = '{32, 32, 12};
  longint m_sx [3][4];
  longint m_sy [3][4];
  longint m_n  [3][4];
  bit     m_ovf[3][4];
  bit     m_lk [3][4];
  bit     m_f  [3][4];
  int     m_px [3][4];
  int     m_py [3][4];

  function automatic void m_reset();
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < 4; c++) begin
        m_sx[d][c] = 0; m_sy[d][c] = 0; m_n[d][c] = 0; m_ovf[d][c] = 0;
        m_lk[d][c] = 0; m_f[d][c] = 0; m_px[d][c] = 0; m_py[d][c] = 0;
      end
  endfunction

  function automatic void m_add(input int c, input int x, input int y);
    longint lim;
    for (int d = 0; d < 3; d++) begin
      if (c >= NC[d]) continue;
      lim = (longint'(1) << AB[d]) - 1;
      m_sx[d][c] += x;
      m_sy[d][c] += y;
      m_n[d][c]  += 1;
      if (m_sx[d][c] > lim) begin m_sx[d][c] = lim; m_ovf[d][c] = 1; end
      if (m_sy[d][c] > lim) begin m_sy[d][c] = lim; m_ovf[d][c] = 1; end
      if (m_n[d][c]  > lim) begin m_n[d][c]  = lim; m_ovf[d][c] = 1; end
    end
  endfunction

  function automatic void m_frame();
    int ax, ay;
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < NC[d]; c++) begin
        m_f[d][c] = (m_n[d][c] >= 16) && !m_ovf[d][c];
        if (m_f[d][c]) begin
          ax = int'((m_sx[d][c] / m_n[d][c]) % 1024);
          ay = int'((m_sy[d][c] / m_n[d][c]) % 512);
          if (m_lk[d][c]) begin
            m_px[d][c] = (m_px[d][c] + ((ax - m_px[d][c]) >>> 1)) & 1023;
            m_py[d][c] = (m_py[d][c] + ((ay - m_py[d][c]) >>> 1)) & 511;
          end else begin
            m_px[d][c] = ax;
            m_py[d][c] = ay;
          end
          m_lk[d][c] = 1;
        end else begin
          m_lk[d][c] = 0;
        end
        m_sx[d][c] = 0; m_sy[d][c] = 0; m_n[d][c] = 0; m_ovf[d][c] = 0;
      end
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    longint ef, ex, ey;
    for (int d = 0; d < 3; d++) begin
      ef = 0; ex = 0; ey = 0;
      for (int c = 0; c < NC[d]; c++) begin
        ef |= longint'(m_f[d][c]) << c;
        ex |= longint'(m_px[d][c]) << (10 * c);
        ey |= longint'(m_py[d][c]) << (9 * c);
      end
      chk($sformatf("%s d%0d found", tag, d), fnd_a[d], ef);
      chk($sformatf("%s d%0d ch_x", tag, d), x_a[d], ex);
      chk($sformatf("%s d%0d ch_y", tag, d), y_a[d], ey);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_px(input int c, input int x, input int y);
    color = 2'(c); pix_x = 10'(x); pix_y = 9'(y); pix_valid = 1'b1;
    m_add(c, x, y);
    step();
    pix_valid = 1'b0;
  endtask

  task automatic burst(input int c, input int x, input int y, input int n);
    for (int i = 0; i < n; i++) send_px(c, x, y);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; frame_flag = 1'b0; pix_valid = 1'b0;
    step();
    reset = 1'b0;
    m_reset();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s d%0d busy", tag, d), busy_w[d], 0);
      chk($sformatf("%s d%0d dropped", tag, d), drop_w[d], 0);
      chk($sformatf("%s d%0d out_valid", tag, d), ovw[d], 0);
    end
    chk_all(tag);
  endtask

  // Raise frame_flag (optionally with a pixel in the edge cycle), time out_valid, check results.
  task automatic end_frame(input bit epx, input int ec, input int ex, input int ey,
                           input int drop_at, input string tag);
    int lat[3];
    bit seen[3];
    for (int d = 0; d < 3; d++) begin lat[d] = 0; seen[d] = 0; end
    frame_flag = 1'b1;
    if (epx) begin
      color = 2'(ec); pix_x = 10'(ex); pix_y = 9'(ey); pix_valid = 1'b1;
      m_add(ec, ex, ey);
    end
    for (int n = 1; n <= 400; n++) begin
      step();
      pix_valid = (n == drop_at);
      if (n == 1)
        for (int d = 0; d < 3; d++) chk($sformatf("%s d%0d busy", tag, d), busy_w[d], 1);
      for (int d = 0; d < 3; d++)
        if (!seen[d] && ovw[d]) begin seen[d] = 1; lat[d] = n; end
      if (seen[0] && seen[1] && seen[2]) break;
    end
    pix_valid = 1'b0;
    step();
    m_frame();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s d%0d latency", tag, d), lat[d], NC[d] * (2 * AB[d] + 1) + 2);
      chk($sformatf("%s d%0d pulse", tag, d), ovw[d], 0);
      chk($sformatf("%s d%0d dropped", tag, d), drop_w[d], (drop_at != 0));
    end
    chk_all(tag);
    frame_flag = 1'b0;
    step();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s d%0d idle busy", tag, d), busy_w[d], 0);
      chk($sformatf("%s d%0d idle dropped", tag, d), drop_w[d], 0);
    end
  endtask

  typedef struct {
    int c0, x0, y0, n0;
    int c1, x1, y1, n1;
    logic [3:0]  ef;
    logic [39:0] ex;
    logic [35:0] ey;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{0, 100, 50, 16, 0, 102, 54, 16, 4'b0001,
                {10'd0, 10'd0, 10'd0, 10'd101}, {9'd0, 9'd0, 9'd0, 9'd52}};
    vecs[1] = '{0, 201, 152, 32, 1, 5, 5, 15, 4'b0001,
                {10'd0, 10'd0, 10'd0, 10'd151}, {9'd0, 9'd0, 9'd0, 9'd102}};
    vecs[2] = '{0, 151, 102, 32, 1, 10, 20, 16, 4'b0011,
                {10'd0, 10'd0, 10'd10, 10'd151}, {9'd0, 9'd0, 9'd20, 9'd102}};
    vecs[3] = '{1, 7, 7, 15, 0, 0, 0, 0, 4'b0000,
                {10'd0, 10'd0, 10'd10, 10'd151}, {9'd0, 9'd0, 9'd20, 9'd102}};
    vecs[4] = '{1, 30, 40, 16, 0, 0, 0, 0, 4'b0010,
                {10'd0, 10'd0, 10'd30, 10'd151}, {9'd0, 9'd0, 9'd40, 9'd102}};
    vecs[5] = '{2, 1023, 511, 16, 3, 500, 300, 16, 4'b1100,
                {10'd500, 10'd1023, 10'd30, 10'd151}, {9'd300, 9'd511, 9'd40, 9'd102}};

    color = '0; pix_x = '0; pix_y = '0; pix_valid = 1'b0; frame_flag = 1'b0; reset = 1'b1;
    step();
    do_reset("init");

    for (int i = 0; i < 6; i++) begin
      burst(vecs[i].c0, vecs[i].x0, vecs[i].y0, vecs[i].n0);
      burst(vecs[i].c1, vecs[i].x1, vecs[i].y1, vecs[i].n1);
      end_frame(1'b0, 0, 0, 0, 0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table found", i), f0, vecs[i].ef);
      chk($sformatf("vec%0d table ch_x", i), x0, vecs[i].ex);
      chk($sformatf("vec%0d table ch_y", i), y0, vecs[i].ey);
    end

    // 16th pixel arrives in the edge cycle; smoothing toward a lower average from (500,300).
    burst(3, 20, 30, 15);
    end_frame(1'b1, 3, 20, 30, 0, "edgepx");
    chk("edgepx found3", f0[3], 1);
    chk("edgepx x3", x0[39:30], 260);
    chk("edgepx y3", y0[35:27], 165);

    // Pixel arriving during DIVX is dropped and flagged.
    burst(0, 300, 200, 20);
    end_frame(1'b0, 0, 0, 0, 5, "drop");

    // Reset mid-ACCUM discards sums and positions.
    burst(1, 400, 100, 20);
    do_reset("rst_accum");
    end_frame(1'b0, 0, 0, 0, 0, "post_rst_accum");

    // Reset mid-DIVY.
    burst(0, 50, 60, 20);
    frame_flag = 1'b1;
    for (int n = 0; n < 50; n++) step();
    chk("mid_divy busy", busy_w[0], 1);
    do_reset("rst_divy");
    end_frame(1'b0, 0, 0, 0, 0, "post_rst_divy");

    // Randomized frames against the model.
    for (int f = 0; f < 8; f++) begin
      int np;
      np = $urandom_range(40, 110);
      for (int i = 0; i < np; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          color = 2'($urandom_range(0, 3)); pix_x = 10'($urandom_range(0, 1023));
          pix_valid = 1'b0;
          step();
        end
        send_px($urandom_range(0, 3), 200 + $urandom_range(0, 300), 100 + $urandom_range(0, 200));
      end
      end_frame(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 1023),
                $urandom_range(0, 511), 0, $sformatf("rand%0d", f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
